// File: rtl/core_bus_check_pkg.sv
// Shared types for the core bus write checker: FSM states, fail causes and the
// expect-entry layout of the default 16-bit address / 16-bit data build.
package core_bus_check_pkg;

  localparam int LANE_W     = 8;
  localparam int REF_ADDR_W = 16;
  localparam int REF_DATA_W = 16;
  localparam int REF_LANES  = REF_DATA_W / LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2
  } chk_state_t;

  typedef enum logic [1:0] {
    CAUSE_MISMATCH   = 2'd0,
    CAUSE_UNEXPECTED = 2'd1,
    CAUSE_TIMEOUT    = 2'd2
  } fail_cause_t;

  typedef struct packed {
    logic [REF_ADDR_W-1:0] addr;
    logic [REF_DATA_W-1:0] data;
    logic [REF_LANES-1:0]  be;
  } exp_entry_t;

endpackage

// File: rtl/bus_expect_fifo.sv
// Synchronous FIFO holding expected write entries; head is visible combinationally.
// Pointers wrap modulo DEPTH (power of 2); caller guarantees no overflow/underflow.
module bus_expect_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdat,
  output logic [WIDTH-1:0]         o_rdat,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wptr] <= i_wdat;
  end

  assign o_rdat  = r_mem[r_rptr];
  assign o_level = r_level;

endmodule

// File: rtl/core_bus_write_checker.sv
// Bus scoreboard: compares core writes against a FIFO of expected entries and counts pass/fail/timeout.
// Optional CORE_BUS_CHECKER_ERRLOG_EN keeps the address/data of the last failing write on ERR_ADDR/ERR_DATA.
module core_bus_write_checker
  import core_bus_check_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic                    EXP_VALID,
  output logic                    EXP_READY,
  input  logic [ADDR_W-1:0]       EXP_ADDR,
  input  logic [DATA_W-1:0]       EXP_DATA,
  input  logic [DATA_W/8-1:0]     EXP_BE,
  input  logic [ADDR_W-1:0]       ADDR_BUF,
  input  logic [DATA_W-1:0]       DOUT_BUF,
  input  logic [DATA_W/8-1:0]     WRN_BUF,
  input  logic                    ABUS_OEN,
  output logic                    PASS_PULSE,
  output logic                    FAIL_PULSE,
  output logic [CNT_W-1:0]        PASS_CNT,
  output logic [CNT_W-1:0]        FAIL_CNT,
  output logic [$clog2(DEPTH):0]  LEVEL,
  output logic                    EMPTY,
  output logic [ADDR_W-1:0]       ERR_ADDR,
  output logic [DATA_W-1:0]       ERR_DATA
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W + LANES;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  be;
  } entry_t;

  chk_state_t         r_state, w_state_nxt;
  logic [LANES-1:0]   r_wrn_prev;
  logic [ADDR_W-1:0]  r_cap_addr;
  logic [DATA_W-1:0]  r_cap_data;
  logic [LANES-1:0]   r_cap_lanes;
  logic               r_unexp;
  logic [TMR_W-1:0]   r_timer;
  logic               r_pass_pulse, r_fail_pulse;
  logic [CNT_W-1:0]   r_pass_cnt, r_fail_cnt;

  logic [ENT_W-1:0]   w_head_raw;
  entry_t             w_head;
  logic [LVL_W-1:0]   w_level, w_level_nxt;
  logic               w_detect, w_accept, w_data_ok, w_match, w_timeout_hit;
  logic               w_pass_vld, w_fail_vld, w_push, w_pop;
  fail_cause_t        w_fail_cause;

  bus_expect_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESETN),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdat  ({EXP_ADDR, EXP_DATA, EXP_BE}),
    .o_rdat  (w_head_raw),
    .o_level (w_level)
  );

  assign w_head    = entry_t'(w_head_raw);
  assign EXP_READY = (w_level != LVL_W'(DEPTH));
  assign EMPTY     = (w_level == '0);
  assign LEVEL     = w_level;

  // Falling edge of any strobe while the core drives the address bus.
  assign w_detect = (~&WRN_BUF) && !ABUS_OEN && (&r_wrn_prev);
  assign w_accept = w_detect && (r_state != ST_CHECK);

  always_comb begin
    w_data_ok = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      if (w_head.be[l] && (r_cap_data[l*LANE_W +: LANE_W] != w_head.data[l*LANE_W +: LANE_W]))
        w_data_ok = 1'b0;
    end
  end

  assign w_match       = (r_cap_addr == w_head.addr) && (r_cap_lanes == w_head.be) && w_data_ok;
  assign w_timeout_hit = (TIMEOUT_CYC != 0) && (r_timer == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    w_pass_vld   = 1'b0;
    w_fail_vld   = 1'b0;
    w_fail_cause = CAUSE_MISMATCH;
    case (r_state)
      ST_CHECK: begin
        if (r_unexp) begin
          w_fail_vld   = 1'b1;
          w_fail_cause = CAUSE_UNEXPECTED;
        end else if (w_match) begin
          w_pass_vld = 1'b1;
        end else begin
          w_fail_vld = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!w_detect && w_timeout_hit) begin
          w_fail_vld   = 1'b1;
          w_fail_cause = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO is taken alongside it.
  assign w_pop       = w_pass_vld || (w_fail_vld && (w_fail_cause != CAUSE_UNEXPECTED));
  assign w_push      = EXP_VALID && (EXP_READY || w_pop);
  assign w_level_nxt = w_level + LVL_W'(w_push) - LVL_W'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_detect) w_state_nxt = ST_CHECK;
                else if (w_push) w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_detect) w_state_nxt = ST_CHECK;
                else if (w_fail_vld) w_state_nxt = (w_level_nxt != '0) ? ST_WAIT : ST_IDLE;
      ST_CHECK: w_state_nxt = (w_level_nxt != '0) ? ST_WAIT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wrn_prev   <= '1;
      r_cap_addr   <= '0;
      r_cap_data   <= '0;
      r_cap_lanes  <= '0;
      r_unexp      <= 1'b0;
      r_timer      <= '0;
      r_pass_pulse <= 1'b0;
      r_fail_pulse <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
    end else begin
      r_wrn_prev <= WRN_BUF;
      if (w_accept) begin
        r_cap_addr  <= ADDR_BUF;
        r_cap_data  <= DOUT_BUF;
        r_cap_lanes <= ~WRN_BUF;
        r_unexp     <= (r_state == ST_IDLE);
      end
      r_timer <= (r_state == ST_WAIT && w_state_nxt == ST_WAIT && !w_fail_vld) ? r_timer + TMR_W'(1) : '0;
      r_pass_pulse <= w_pass_vld;
      r_fail_pulse <= w_fail_vld;
      if (w_pass_vld && !(&r_pass_cnt)) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
      if (w_fail_vld && !(&r_fail_cnt)) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
    end
  end

  assign PASS_PULSE = r_pass_pulse;
  assign FAIL_PULSE = r_fail_pulse;
  assign PASS_CNT   = r_pass_cnt;
  assign FAIL_CNT   = r_fail_cnt;

`ifdef CORE_BUS_CHECKER_ERRLOG_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [DATA_W-1:0] r_err_data;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_err_addr <= '0;
      r_err_data <= '0;
    end else if (w_fail_vld && (w_fail_cause != CAUSE_TIMEOUT)) begin
      r_err_addr <= r_cap_addr;
      r_err_data <= r_cap_data;
    end
  end

  assign ERR_ADDR = r_err_addr;
  assign ERR_DATA = r_err_data;
`else
  assign ERR_ADDR = '0;
  assign ERR_DATA = '0;
`endif

endmodule

// File: tb/tb_core_bus_write_checker.sv
// Bench for core_bus_write_checker (DEPTH=4, TIMEOUT_CYC=16) against a queue-based reference model.
module tb_core_bus_write_checker;
  import core_bus_check_pkg::*;

  localparam int DEPTH       = 4;
  localparam int TIMEOUT_CYC = 16;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        EXP_VALID, EXP_READY;
  logic [15:0] EXP_ADDR, EXP_DATA;
  logic [1:0]  EXP_BE;
  logic [15:0] ADDR_BUF, DOUT_BUF;
  logic [1:0]  WRN_BUF;
  logic        ABUS_OEN;
  logic        PASS_PULSE, FAIL_PULSE;
  logic [15:0] PASS_CNT, FAIL_CNT;
  logic [2:0]  LEVEL;
  logic        EMPTY;
  logic [15:0] ERR_ADDR, ERR_DATA;

  always #5 CLK = ~CLK;

  core_bus_write_checker #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .CNT_W(16), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .EXP_VALID(EXP_VALID), .EXP_READY(EXP_READY),
    .EXP_ADDR(EXP_ADDR), .EXP_DATA(EXP_DATA), .EXP_BE(EXP_BE),
    .ADDR_BUF(ADDR_BUF), .DOUT_BUF(DOUT_BUF), .WRN_BUF(WRN_BUF), .ABUS_OEN(ABUS_OEN),
    .PASS_PULSE(PASS_PULSE), .FAIL_PULSE(FAIL_PULSE),
    .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT),
    .LEVEL(LEVEL), .EMPTY(EMPTY),
    .ERR_ADDR(ERR_ADDR), .ERR_DATA(ERR_DATA)
  );

  int checks = 0;
  int failures = 0;

  exp_entry_t  exp_q[$];
  int          m_pass = 0;
  int          m_fail = 0;
  logic [15:0] m_err_addr = '0;
  logic [15:0] m_err_data = '0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [15:0] want_err_addr();
`ifdef CORE_BUS_CHECKER_ERRLOG_EN
    return m_err_addr;
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [15:0] want_err_data();
`ifdef CORE_BUS_CHECKER_ERRLOG_EN
    return m_err_data;
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_push(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    exp_entry_t e;
    e.addr = a; e.data = d; e.be = be;
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
  endtask

  // One core write judged by the rules: empty queue -> unexpected; else exact addr and lane set, masked data.
  task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] lanes,
                             output logic ep, output logic ef);
    exp_entry_t h;
    ep = 1'b0;
    ef = 1'b1;
    if (exp_q.size() != 0) begin
      h = exp_q.pop_front();
      ep = (a == h.addr) && (lanes == h.be) && (((d ^ h.data) & lane_mask(h.be)) == 16'h0);
      ef = !ep;
    end
    if (ep) m_pass++;
    if (ef) begin
      m_fail++;
      m_err_addr = a;
      m_err_data = d;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pass = 0; m_fail = 0; m_err_addr = '0; m_err_data = '0;
  endtask

  task automatic do_push(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be, output logic rdy);
    EXP_VALID = 1'b1; EXP_ADDR = a; EXP_DATA = d; EXP_BE = be;
    rdy = EXP_READY;
    tick();
    EXP_VALID = 1'b0;
  endtask

  task automatic drive_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] wrn, input logic oen,
                             output logic early, output logic p, output logic f);
    ADDR_BUF = a; DOUT_BUF = d; WRN_BUF = wrn; ABUS_OEN = oen;
    tick();
    early = PASS_PULSE | FAIL_PULSE;
    WRN_BUF = 2'b11; ABUS_OEN = 1'b1;
    tick();
    p = PASS_PULSE;
    f = FAIL_PULSE;
  endtask

  task automatic test_reset();
    RESETN = 1'b0;
    EXP_VALID = 0; EXP_ADDR = '0; EXP_DATA = '0; EXP_BE = '0;
    ADDR_BUF = '0; DOUT_BUF = '0; WRN_BUF = 2'b11; ABUS_OEN = 1'b1;
    repeat (3) tick();
    checks++; if (LEVEL !== 3'd0) begin failures++; $display("FAIL reset_level got %0d want 0", LEVEL); end
    checks++; if (EMPTY !== 1'b1 || EXP_READY !== 1'b1) begin failures++; $display("FAIL reset_flags got empty=%b rdy=%b want 1 1", EMPTY, EXP_READY); end
    checks++; if (PASS_CNT !== 16'd0 || FAIL_CNT !== 16'd0) begin failures++; $display("FAIL reset_cnt got %0d/%0d want 0/0", PASS_CNT, FAIL_CNT); end
    checks++; if ({PASS_PULSE, FAIL_PULSE} !== 2'b00) begin failures++; $display("FAIL reset_pulse got %b want 00", {PASS_PULSE, FAIL_PULSE}); end
    checks++; if (ERR_ADDR !== 16'h0 || ERR_DATA !== 16'h0) begin failures++; $display("FAIL reset_err got %h/%h want 0/0", ERR_ADDR, ERR_DATA); end
    @(negedge CLK);
    RESETN = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic test_match();
    logic rdy, early, p, f, ep, ef;
    do_push(16'hFAAF, 16'hFFAF, 2'b11, rdy);
    model_push(16'hFAAF, 16'hFFAF, 2'b11);
    model_write(16'hFAAF, 16'hFFAF, 2'b11, ep, ef);
    drive_write(16'hFAAF, 16'hFFAF, 2'b00, 1'b0, early, p, f);
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL match_early got %b want 0", early); end
    checks++; if (p !== ep || f !== ef) begin failures++; $display("FAIL match_pulse got %b%b want %b%b", p, f, ep, ef); end
    checks++; if (PASS_CNT !== 16'(m_pass)) begin failures++; $display("FAIL match_cnt got %0d want %0d", PASS_CNT, m_pass); end
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL match_empty got %b want 1", EMPTY); end
  endtask

  task automatic test_mismatch();
    logic rdy, early, p, f, ep, ef;
    do_push(16'hFAAF, 16'h00FA, 2'b11, rdy);
    model_push(16'hFAAF, 16'h00FA, 2'b11);
    model_write(16'hFAAF, 16'h00FB, 2'b11, ep, ef);
    drive_write(16'hFAAF, 16'h00FB, 2'b00, 1'b0, early, p, f);
    checks++; if (p !== ep || f !== ef) begin failures++; $display("FAIL mismatch_pulse got %b%b want %b%b", p, f, ep, ef); end
    checks++; if (FAIL_CNT !== 16'(m_fail)) begin failures++; $display("FAIL mismatch_cnt got %0d want %0d", FAIL_CNT, m_fail); end
    checks++; if (ERR_DATA !== want_err_data()) begin failures++; $display("FAIL mismatch_errdata got %h want %h", ERR_DATA, want_err_data()); end
  endtask

  task automatic test_byte_lane();
    logic rdy, early, p, f, ep, ef;
    do_push(16'h4040, 16'h00AA, 2'b01, rdy);
    model_push(16'h4040, 16'h00AA, 2'b01);
    model_write(16'h4040, 16'h55AA, 2'b01, ep, ef);
    drive_write(16'h4040, 16'h55AA, 2'b10, 1'b0, early, p, f);
    checks++; if (p !== ep || f !== ef) begin failures++; $display("FAIL lane_masked got %b%b want %b%b", p, f, ep, ef); end
    do_push(16'h4040, 16'h00AA, 2'b01, rdy);
    model_push(16'h4040, 16'h00AA, 2'b01);
    model_write(16'h4040, 16'h55AA, 2'b11, ep, ef);
    drive_write(16'h4040, 16'h55AA, 2'b00, 1'b0, early, p, f);
    checks++; if (p !== ep || f !== ef) begin failures++; $display("FAIL lane_set got %b%b want %b%b", p, f, ep, ef); end
    checks++; if (PASS_CNT !== 16'(m_pass) || FAIL_CNT !== 16'(m_fail)) begin failures++; $display("FAIL lane_cnt got %0d/%0d want %0d/%0d", PASS_CNT, FAIL_CNT, m_pass, m_fail); end
  endtask

  task automatic test_unexpected();
    logic early, p, f, ep, ef;
    model_write(16'h3333, 16'h1234, 2'b11, ep, ef);
    drive_write(16'h3333, 16'h1234, 2'b00, 1'b0, early, p, f);
    checks++; if (p !== ep || f !== ef) begin failures++; $display("FAIL unexp_pulse got %b%b want %b%b", p, f, ep, ef); end
    checks++; if (LEVEL !== 3'd0) begin failures++; $display("FAIL unexp_level got %0d want 0", LEVEL); end
    checks++; if (ERR_ADDR !== want_err_addr()) begin failures++; $display("FAIL unexp_erraddr got %h want %h", ERR_ADDR, want_err_addr()); end
  endtask

  task automatic test_timeout();
    logic rdy;
    int   seen = 0;
    do_push(16'h0BAD, 16'hC0DE, 2'b11, rdy);
    model_push(16'h0BAD, 16'hC0DE, 2'b11);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (FAIL_PULSE === 1'b1) begin
        seen = i;
        break;
      end
    end
    void'(exp_q.pop_front());
    m_fail++;
    checks++; if (seen != TIMEOUT_CYC) begin failures++; $display("FAIL timeout_latency got %0d want %0d", seen, TIMEOUT_CYC); end
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL timeout_empty got %b want 1", EMPTY); end
    checks++; if (FAIL_CNT !== 16'(m_fail)) begin failures++; $display("FAIL timeout_cnt got %0d want %0d", FAIL_CNT, m_fail); end
    checks++; if (ERR_ADDR !== want_err_addr()) begin failures++; $display("FAIL timeout_erraddr got %h want %h", ERR_ADDR, want_err_addr()); end
    tick();
  endtask

  task automatic test_full_and_reset();
    logic rdy, ep, ef;
    exp_entry_t h;
    for (int i = 0; i < DEPTH; i++) begin
      do_push(16'(16'h1000 + i), 16'($urandom), 2'(1 + i % 3), rdy);
      model_push(16'(16'h1000 + i), EXP_DATA, 2'(1 + i % 3));
    end
    checks++; if (EXP_READY !== 1'b0 || LEVEL !== 3'd4) begin failures++; $display("FAIL full_ready got rdy=%b lvl=%0d want 0 4", EXP_READY, LEVEL); end
    do_push(16'hDEAD, 16'hBEEF, 2'b11, rdy);
    model_push(16'hDEAD, 16'hBEEF, 2'b11);
    checks++; if (rdy !== 1'b0 || LEVEL !== 3'(exp_q.size())) begin failures++; $display("FAIL full_ignore got rdy=%b lvl=%0d want 0 %0d", rdy, LEVEL, exp_q.size()); end
    h = exp_q[0];
    ADDR_BUF = h.addr; DOUT_BUF = h.data; WRN_BUF = ~h.be; ABUS_OEN = 1'b0;
    tick();
    WRN_BUF = 2'b11; ABUS_OEN = 1'b1;
    EXP_VALID = 1'b1; EXP_ADDR = 16'h2222; EXP_DATA = 16'h3333; EXP_BE = 2'b11;
    tick();
    EXP_VALID = 1'b0;
    model_write(h.addr, h.data, h.be, ep, ef);
    model_push(16'h2222, 16'h3333, 2'b11);
    checks++; if (PASS_PULSE !== ep) begin failures++; $display("FAIL pushpop_pulse got %b want %b", PASS_PULSE, ep); end
    checks++; if (LEVEL !== 3'(exp_q.size())) begin failures++; $display("FAIL pushpop_level got %0d want %0d", LEVEL, exp_q.size()); end
    h = exp_q[0];
    ADDR_BUF = h.addr; DOUT_BUF = h.data; WRN_BUF = ~h.be; ABUS_OEN = 1'b0;
    tick();
    WRN_BUF = 2'b11; ABUS_OEN = 1'b1;
    #1 RESETN = 1'b0;
    #1;
    model_reset();
    checks++; if (PASS_CNT !== 16'd0 || FAIL_CNT !== 16'd0) begin failures++; $display("FAIL midrst_cnt got %0d/%0d want 0/0", PASS_CNT, FAIL_CNT); end
    checks++; if (EMPTY !== 1'b1 || LEVEL !== 3'd0) begin failures++; $display("FAIL midrst_empty got %b/%0d want 1/0", EMPTY, LEVEL); end
    @(negedge CLK);
    RESETN = 1'b1;
    tick();
    tick();
    checks++; if ({PASS_PULSE, FAIL_PULSE} !== 2'b00 || PASS_CNT !== 16'd0) begin failures++; $display("FAIL midrst_pulse got %b cnt=%0d want 00 0", {PASS_PULSE, FAIL_PULSE}, PASS_CNT); end
  endtask

  task automatic test_random();
    logic        rdy, early, p, f, ep, ef, want_rdy;
    logic [15:0] a, d;
    logic [1:0]  l;
    exp_entry_t  h;
    for (int it = 0; it < 150; it++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        a = 16'($urandom); d = 16'($urandom); l = 2'($urandom_range(1, 3));
        want_rdy = (exp_q.size() < DEPTH);
        do_push(a, d, l, rdy);
        model_push(a, d, l);
        checks++; if (rdy !== want_rdy) begin failures++; $display("FAIL rand_ready it=%0d got %b want %b", it, rdy, want_rdy); end
      end
      if ($urandom_range(0, 7) == 0) begin
        drive_write(16'($urandom), 16'($urandom), 2'b00, 1'b1, early, p, f);
        checks++; if ({p, f} !== 2'b00) begin failures++; $display("FAIL rand_oen it=%0d got %b want 00", it, {p, f}); end
      end
      if (exp_q.size() == 0) begin
        a = 16'($urandom); d = 16'($urandom); l = 2'($urandom_range(1, 3));
      end else begin
        h = exp_q[0];
        a = h.addr; d = h.data; l = h.be;
        case ($urandom_range(0, 4))
          1: d = d ^ (16'h1 << $urandom_range(0, 15));
          2: d = d ^ (~lane_mask(h.be) & 16'($urandom));
          3: a = a ^ (16'h1 << $urandom_range(0, 15));
          4: l = 2'($urandom_range(1, 3));
          default: ;
        endcase
      end
      model_write(a, d, l, ep, ef);
      drive_write(a, d, ~l, 1'b0, early, p, f);
      checks++; if (early !== 1'b0) begin failures++; $display("FAIL rand_early it=%0d got %b want 0", it, early); end
      checks++; if (p !== ep || f !== ef) begin failures++; $display("FAIL rand_pulse it=%0d got %b%b want %b%b", it, p, f, ep, ef); end
      checks++; if (PASS_CNT !== 16'(m_pass) || FAIL_CNT !== 16'(m_fail)) begin failures++; $display("FAIL rand_cnt it=%0d got %0d/%0d want %0d/%0d", it, PASS_CNT, FAIL_CNT, m_pass, m_fail); end
      checks++; if (LEVEL !== 3'(exp_q.size())) begin failures++; $display("FAIL rand_level it=%0d got %0d want %0d", it, LEVEL, exp_q.size()); end
      checks++; if (ERR_DATA !== want_err_data()) begin failures++; $display("FAIL rand_errdata it=%0d got %h want %h", it, ERR_DATA, want_err_data()); end
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_byte_lane();
    test_unexpected();
    test_timeout();
    test_full_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
